// File: rtl/bsg_hbm_adapter_pkg.sv
// Shared payload types and width helpers for the per-channel HBM request adapter.
// The structs describe the default channel configuration; the helpers size non-default builds.
package bsg_hbm_adapter_pkg;

  localparam int hbm_ch_addr_width_gp = 29;
  localparam int hbm_data_width_gp    = 512;
  localparam int hbm_mask_width_gp    = hbm_data_width_gp >> 3;

  typedef struct packed {
    logic                            write_not_read;
    logic [hbm_ch_addr_width_gp-1:0] ch_addr;
  } bsg_hbm_cmd_s;

  typedef struct packed {
    logic [hbm_data_width_gp-1:0] data;
    logic [hbm_mask_width_gp-1:0] mask;
  } bsg_hbm_wbeat_s;

  function automatic int cmd_width_f(input int addr_width);
    return 1 + addr_width;
  endfunction

  function automatic int wbeat_width_f(input int data_width);
    return data_width + (data_width >> 3);
  endfunction

endpackage

// File: rtl/bsg_counter_up_down.sv
// Saturation-free up/down counter; callers keep it inside [0, max_val_p].
module bsg_counter_up_down #(
  parameter  int max_val_p     = 16,
  parameter  int init_val_p    = 0,
  parameter  int max_step_p    = 1,
  localparam int step_width_lp = $clog2(max_step_p + 1),
  localparam int ptr_width_lp  = $clog2(max_val_p + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [step_width_lp-1:0] up_i,
  input  logic [step_width_lp-1:0] down_i,
  output logic [ptr_width_lp-1:0]  count_o
);

  logic [ptr_width_lp-1:0] count_q, count_d;

  assign count_o = count_q;

  always_comb begin
    count_d = count_q + ptr_width_lp'(up_i) - ptr_width_lp'(down_i);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)
      count_q <= ptr_width_lp'(init_val_p);
    else
      count_q <= count_d;
  end

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read one-write FIFO; ready_o comes from the registered occupancy only,
// so a full FIFO refuses a push even in a cycle where it is also being popped.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int count_width_lp = $clog2(els_p + 1);

  logic [width_p-1:0]        mem_q [els_p];
  logic [ptr_width_lp-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [count_width_lp-1:0] count_q, count_d;
  logic                      push, pop;

  assign ready_o = (count_q != count_width_lp'(els_p));
  assign v_o     = (count_q != '0);
  assign data_o  = mem_q[rptr_q];
  assign push    = v_i & ready_o;
  assign pop     = yumi_i & v_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + count_width_lp'(push) - count_width_lp'(pop);
    if (push)
      wptr_d = (wptr_q == ptr_width_lp'(els_p - 1)) ? '0 : wptr_q + ptr_width_lp'(1);
    if (pop)
      rptr_d = (rptr_q == ptr_width_lp'(els_p - 1)) ? '0 : rptr_q + ptr_width_lp'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (push)
      mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/bsg_hbm_channel_req_adapter.sv
// Splits one client request stream onto the HBM command and write-data handshakes,
// limits in-flight reads with a credit counter and registers read returns for the client.
module bsg_hbm_channel_req_adapter
  import bsg_hbm_adapter_pkg::*;
#(
  parameter int channel_addr_width_p = hbm_ch_addr_width_gp,
  parameter int data_width_p         = hbm_data_width_gp,
  parameter int cmd_els_p            = 4,
  parameter int wdata_els_p          = 4,
  parameter int max_reads_p          = 16
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   v_i,
  input  logic                                   write_not_read_i,
  input  logic [channel_addr_width_p-1:0]        addr_i,
  input  logic [data_width_p-1:0]                data_i,
  input  logic [(data_width_p>>3)-1:0]           mask_i,
  output logic                                   ready_and_o,
  output logic                                   hbm_v_o,
  output logic                                   hbm_write_not_read_o,
  output logic [channel_addr_width_p-1:0]        hbm_ch_addr_o,
  input  logic                                   hbm_yumi_i,
  output logic                                   hbm_data_v_o,
  output logic [data_width_p-1:0]                hbm_data_o,
  output logic [(data_width_p>>3)-1:0]           hbm_mask_o,
  input  logic                                   hbm_data_yumi_i,
  input  logic                                   hbm_data_v_i,
  input  logic [data_width_p-1:0]                hbm_data_i,
  input  logic [channel_addr_width_p-1:0]        hbm_read_done_ch_addr_i,
  output logic                                   resp_v_o,
  output logic [data_width_p-1:0]                resp_data_o,
  output logic [channel_addr_width_p-1:0]        resp_addr_o,
  output logic [$clog2(max_reads_p+1)-1:0]       reads_outstanding_o,
  output logic                                   idle_o,
  output logic                                   error_o
);

  localparam int mask_width_lp  = data_width_p >> 3;
  localparam int cmd_width_lp   = cmd_width_f(channel_addr_width_p);
  localparam int wbeat_width_lp = wbeat_width_f(data_width_p);
  localparam int count_width_lp = $clog2(max_reads_p + 1);

  typedef struct packed {
    logic                            write_not_read;
    logic [channel_addr_width_p-1:0] ch_addr;
  } cmd_s;

  typedef struct packed {
    logic [data_width_p-1:0]  data;
    logic [mask_width_lp-1:0] mask;
  } wbeat_s;

  cmd_s   cmd_li, cmd_lo;
  wbeat_s wbeat_li, wbeat_lo;
  logic   cmd_ready_lo, cmd_v_lo, wdata_ready_lo, wdata_v_lo;
  logic   credit_avail, accept, wdata_push, read_accept, read_return;

  logic                            resp_v_q, resp_v_d;
  logic [data_width_p-1:0]         resp_data_q, resp_data_d;
  logic [channel_addr_width_p-1:0] resp_addr_q, resp_addr_d;
  logic                            error_q, error_d;

  // Credit check uses the registered count, so a same-cycle return never frees a slot early.
  assign credit_avail = (reads_outstanding_o < count_width_lp'(max_reads_p));
  assign ready_and_o  = ~reset_i & cmd_ready_lo
                      & (write_not_read_i ? wdata_ready_lo : credit_avail);
  assign accept       = v_i & ready_and_o;
  assign wdata_push   = accept & write_not_read_i;
  assign read_accept  = accept & ~write_not_read_i;
  assign read_return  = hbm_data_v_i & (reads_outstanding_o != '0);

  assign cmd_li   = '{write_not_read: write_not_read_i, ch_addr: addr_i};
  assign wbeat_li = '{data: data_i, mask: mask_i};

  bsg_fifo_1r1w_small #(.width_p(cmd_width_lp), .els_p(cmd_els_p)) cmd_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (accept),
    .ready_o(cmd_ready_lo),
    .data_i (cmd_li),
    .v_o    (cmd_v_lo),
    .data_o (cmd_lo),
    .yumi_i (hbm_yumi_i)
  );

  bsg_fifo_1r1w_small #(.width_p(wbeat_width_lp), .els_p(wdata_els_p)) wdata_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (wdata_push),
    .ready_o(wdata_ready_lo),
    .data_i (wbeat_li),
    .v_o    (wdata_v_lo),
    .data_o (wbeat_lo),
    .yumi_i (hbm_data_yumi_i)
  );

  bsg_counter_up_down #(.max_val_p(max_reads_p), .init_val_p(0), .max_step_p(1)) read_credits (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .up_i   (read_accept),
    .down_i (read_return),
    .count_o(reads_outstanding_o)
  );

  assign hbm_v_o              = cmd_v_lo;
  assign hbm_write_not_read_o = cmd_lo.write_not_read;
  assign hbm_ch_addr_o        = cmd_lo.ch_addr;
  assign hbm_data_v_o         = wdata_v_lo;
  assign hbm_data_o           = wbeat_lo.data;
  assign hbm_mask_o           = wbeat_lo.mask;

  // A return with no reads in flight is still forwarded but flags a protocol error.
  always_comb begin
    resp_v_d    = hbm_data_v_i;
    resp_data_d = resp_data_q;
    resp_addr_d = resp_addr_q;
    error_d     = error_q;
    if (hbm_data_v_i) begin
      resp_data_d = hbm_data_i;
      resp_addr_d = hbm_read_done_ch_addr_i;
      if (reads_outstanding_o == '0)
        error_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      resp_v_q    <= 1'b0;
      resp_data_q <= '0;
      resp_addr_q <= '0;
      error_q     <= 1'b0;
    end else begin
      resp_v_q    <= resp_v_d;
      resp_data_q <= resp_data_d;
      resp_addr_q <= resp_addr_d;
      error_q     <= error_d;
    end
  end

  assign resp_v_o    = resp_v_q;
  assign resp_data_o = resp_data_q;
  assign resp_addr_o = resp_addr_q;
  assign error_o     = error_q;
  assign idle_o      = ~cmd_v_lo & ~wdata_v_lo & (reads_outstanding_o == '0);

endmodule

// File: tb/tb_bsg_hbm_channel_req_adapter.sv
// Bench for the HBM channel request adapter: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a queue-based reference model.
module tb_bsg_hbm_channel_req_adapter;

  localparam int aw        = 29;
  localparam int dw        = 512;
  localparam int mw        = dw >> 3;
  localparam int cmd_els   = 4;
  localparam int wd_els    = 4;
  localparam int max_reads = 16;
  localparam int cw        = $clog2(max_reads + 1);

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          reset_i, v_i, write_not_read_i, hbm_yumi_i, hbm_data_yumi_i, hbm_data_v_i;
  logic [aw-1:0] addr_i, hbm_read_done_ch_addr_i;
  logic [dw-1:0] data_i, hbm_data_i;
  logic [mw-1:0] mask_i;

  logic          ready_and_o, hbm_v_o, hbm_write_not_read_o, hbm_data_v_o;
  logic          resp_v_o, idle_o, error_o;
  logic [aw-1:0] hbm_ch_addr_o, resp_addr_o;
  logic [dw-1:0] hbm_data_o, resp_data_o;
  logic [mw-1:0] hbm_mask_o;
  logic [cw-1:0] reads_outstanding_o;

  bsg_hbm_channel_req_adapter #(
    .channel_addr_width_p(aw), .data_width_p(dw), .cmd_els_p(cmd_els),
    .wdata_els_p(wd_els), .max_reads_p(max_reads)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .write_not_read_i(write_not_read_i),
    .addr_i(addr_i), .data_i(data_i), .mask_i(mask_i), .ready_and_o(ready_and_o),
    .hbm_v_o(hbm_v_o), .hbm_write_not_read_o(hbm_write_not_read_o),
    .hbm_ch_addr_o(hbm_ch_addr_o), .hbm_yumi_i(hbm_yumi_i),
    .hbm_data_v_o(hbm_data_v_o), .hbm_data_o(hbm_data_o), .hbm_mask_o(hbm_mask_o),
    .hbm_data_yumi_i(hbm_data_yumi_i), .hbm_data_v_i(hbm_data_v_i),
    .hbm_data_i(hbm_data_i), .hbm_read_done_ch_addr_i(hbm_read_done_ch_addr_i),
    .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_addr_o(resp_addr_o),
    .reads_outstanding_o(reads_outstanding_o), .idle_o(idle_o), .error_o(error_o)
  );

  typedef struct packed { logic wnr; logic [aw-1:0] addr; } m_cmd_t;
  typedef struct packed { logic [dw-1:0] data; logic [mw-1:0] mask; } m_beat_t;

  m_cmd_t        m_cmds[$];
  m_beat_t       m_beats[$];
  int            m_reads = 0;
  bit            m_err = 1'b0;
  bit            m_resp_v = 1'b0;
  logic [dw-1:0] m_resp_data = '0;
  logic [aw-1:0] m_resp_addr = '0;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [dw-1:0] act, input logic [dw-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [dw-1:0] rand_data();
    logic [dw-1:0] r;
    for (int i = 0; i < dw / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // What the client should see as ready, from queue occupancy and credits alone.
  function automatic bit model_ready();
    if (reset_i) return 1'b0;
    if (m_cmds.size() >= cmd_els) return 1'b0;
    if (write_not_read_i) return m_beats.size() < wd_els;
    return m_reads < max_reads;
  endfunction

  task automatic checkOutput();
    chk("ready_and", ready_and_o, model_ready());
    chk("hbm_v", hbm_v_o, m_cmds.size() != 0);
    if (m_cmds.size() != 0) begin
      chk("hbm_wnr", hbm_write_not_read_o, m_cmds[0].wnr);
      chk("hbm_addr", hbm_ch_addr_o, m_cmds[0].addr);
    end
    chk("hbm_data_v", hbm_data_v_o, m_beats.size() != 0);
    if (m_beats.size() != 0) begin
      chk("hbm_data", hbm_data_o, m_beats[0].data);
      chk("hbm_mask", hbm_mask_o, m_beats[0].mask);
    end
    chk("reads_out", reads_outstanding_o, m_reads);
    chk("idle", idle_o, m_cmds.size() == 0 && m_beats.size() == 0 && m_reads == 0);
    chk("error", error_o, m_err);
    chk("resp_v", resp_v_o, m_resp_v);
    if (m_resp_v) begin
      chk("resp_data", resp_data_o, m_resp_data);
      chk("resp_addr", resp_addr_o, m_resp_addr);
    end
  endtask

  task automatic stepModel();
    bit acc;
    acc = v_i && model_ready();
    if (reset_i) begin
      m_cmds.delete();
      m_beats.delete();
      m_reads  = 0;
      m_err    = 1'b0;
      m_resp_v = 1'b0;
      return;
    end
    if (hbm_yumi_i && m_cmds.size() != 0) void'(m_cmds.pop_front());
    if (hbm_data_yumi_i && m_beats.size() != 0) void'(m_beats.pop_front());
    if (acc) begin
      m_cmds.push_back({write_not_read_i, addr_i});
      if (write_not_read_i) m_beats.push_back({data_i, mask_i});
    end
    m_resp_v = hbm_data_v_i;
    if (hbm_data_v_i) begin
      m_resp_data = hbm_data_i;
      m_resp_addr = hbm_read_done_ch_addr_i;
      if (m_reads == 0) m_err = 1'b1;
      else m_reads--;
    end
    if (acc && !write_not_read_i) m_reads++;
  endtask

  task automatic applyStimulus(input bit v, input bit wnr, input logic [aw-1:0] addr,
                               input logic [dw-1:0] data, input logic [mw-1:0] mask,
                               input bit yumi, input bit dyumi, input bit rv,
                               input logic [dw-1:0] rdata, input logic [aw-1:0] raddr);
    v_i                     = v;
    write_not_read_i        = wnr;
    addr_i                  = addr;
    data_i                  = data;
    mask_i                  = mask;
    hbm_yumi_i              = yumi;
    hbm_data_yumi_i         = dyumi;
    hbm_data_v_i            = rv;
    hbm_data_i              = rdata;
    hbm_read_done_ch_addr_i = raddr;
    #1;
  endtask

  task automatic idleStim(input bit yumi, input bit dyumi);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, yumi, dyumi, 1'b0, '0, '0);
  endtask

  task automatic readStim(input bit yumi, input bit rv);
    applyStimulus(1'b1, 1'b0, aw'($urandom), '0, '0, yumi, 1'b1, rv, rand_data(), aw'($urandom));
  endtask

  task automatic returnStim();
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b1, rand_data(), aw'($urandom));
  endtask

  task automatic runCycle();
    checkOutput();
    stepModel();
    @(negedge clk_i);
  endtask

  logic [dw-1:0] a5_data;
  logic [dw-1:0] ret_data;
  logic [mw-1:0] ones_mask;

  initial begin
    a5_data   = {(dw/8){8'hA5}};
    ones_mask = '1;
    reset_i   = 1'b1;
    v_i = 1'b0; write_not_read_i = 1'b0; addr_i = '0; data_i = '0; mask_i = '0;
    hbm_yumi_i = 1'b0; hbm_data_yumi_i = 1'b0; hbm_data_v_i = 1'b0;
    hbm_data_i = '0; hbm_read_done_ch_addr_i = '0;
    @(negedge clk_i);

    idleStim(1'b0, 1'b0);
    chk("rst_ready", ready_and_o, 1'b0);
    chk("rst_hbm_v", hbm_v_o, 1'b0);
    chk("rst_idle", idle_o, 1'b1);
    chk("rst_count", reads_outstanding_o, 0);
    runCycle();
    reset_i = 1'b0;

    // Single write reaches both HBM handshakes one cycle later.
    applyStimulus(1'b1, 1'b1, aw'(32'h100), a5_data, ones_mask, 1'b1, 1'b1, 1'b0, '0, '0);
    chk("wr_ready", ready_and_o, 1'b1);
    runCycle();
    idleStim(1'b1, 1'b1);
    chk("wr_hbm_v", hbm_v_o, 1'b1);
    chk("wr_wnr", hbm_write_not_read_o, 1'b1);
    chk("wr_addr", hbm_ch_addr_o, 29'h100);
    chk("wr_data_v", hbm_data_v_o, 1'b1);
    chk("wr_data", hbm_data_o, a5_data);
    runCycle();
    idleStim(1'b1, 1'b1);
    chk("wr_idle", idle_o, 1'b1);
    runCycle();

    // Five reads into a four-deep command FIFO with the HBM stalled.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, aw'(16 * i), '0, '0, 1'b0, 1'b1, 1'b0, '0, '0);
      chk("stall_ready", ready_and_o, i < 4);
      runCycle();
    end
    applyStimulus(1'b1, 1'b0, aw'(32'h40), '0, '0, 1'b1, 1'b1, 1'b0, '0, '0);
    chk("stall_release_ready", ready_and_o, 1'b0);
    chk("stall_head", hbm_ch_addr_o, 29'h0);
    runCycle();
    applyStimulus(1'b1, 1'b0, aw'(32'h40), '0, '0, 1'b1, 1'b1, 1'b0, '0, '0);
    chk("stall_fifth_ready", ready_and_o, 1'b1);
    runCycle();
    for (int n = 0; n < 20 && m_cmds.size() != 0; n++) begin
      idleStim(1'b1, 1'b1);
      runCycle();
    end
    idleStim(1'b1, 1'b1);
    chk("stall_drained", hbm_v_o, 1'b0);

    // Read return is registered for the client and frees one credit.
    ret_data = rand_data();
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b1, ret_data, aw'(32'h2A0));
    chk("ret_count_before", reads_outstanding_o, 5);
    runCycle();
    idleStim(1'b1, 1'b1);
    chk("ret_resp_v", resp_v_o, 1'b1);
    chk("ret_resp_addr", resp_addr_o, 29'h2A0);
    chk("ret_resp_data", resp_data_o, ret_data);
    chk("ret_count_after", reads_outstanding_o, 4);
    runCycle();
    for (int i = 0; i < 4; i++) begin
      returnStim();
      runCycle();
    end

    // Credit limit: the 17th read waits while writes still flow.
    for (int i = 0; i < 16; i++) begin
      readStim(1'b1, 1'b0);
      runCycle();
    end
    readStim(1'b1, 1'b0);
    chk("lim_ready_read", ready_and_o, 1'b0);
    chk("lim_count16", reads_outstanding_o, 16);
    runCycle();
    applyStimulus(1'b1, 1'b1, aw'($urandom), rand_data(), ones_mask, 1'b1, 1'b1, 1'b0, '0, '0);
    chk("lim_ready_write", ready_and_o, 1'b1);
    runCycle();
    readStim(1'b1, 1'b1);
    chk("lim_same_cycle_ready", ready_and_o, 1'b0);
    runCycle();
    readStim(1'b1, 1'b0);
    chk("lim_count15", reads_outstanding_o, 15);
    chk("lim_ready_next", ready_and_o, 1'b1);
    runCycle();
    idleStim(1'b1, 1'b1);
    chk("lim_count16_again", reads_outstanding_o, 16);
    runCycle();
    for (int i = 0; i < 16; i++) begin
      returnStim();
      runCycle();
    end

    // Simultaneous read accept and return leaves the count unchanged.
    for (int i = 0; i < 5; i++) begin
      readStim(1'b1, 1'b0);
      runCycle();
    end
    readStim(1'b1, 1'b1);
    chk("same_ready", ready_and_o, 1'b1);
    chk("same_count_before", reads_outstanding_o, 5);
    runCycle();
    idleStim(1'b1, 1'b1);
    chk("same_count_after", reads_outstanding_o, 5);
    runCycle();
    for (int i = 0; i < 5; i++) begin
      returnStim();
      runCycle();
    end

    // Spurious return sets a sticky error; reset clears everything queued.
    returnStim();
    runCycle();
    idleStim(1'b1, 1'b1);
    chk("err_set", error_o, 1'b1);
    runCycle();
    for (int i = 0; i < 3; i++) begin
      readStim(1'b0, 1'b0);
      runCycle();
    end
    idleStim(1'b0, 1'b0);
    chk("err_sticky", error_o, 1'b1);
    reset_i = 1'b1;
    idleStim(1'b0, 1'b0);
    runCycle();
    reset_i = 1'b0;
    returnStim();
    chk("post_rst_hbm_v", hbm_v_o, 1'b0);
    chk("post_rst_count", reads_outstanding_o, 0);
    chk("post_rst_error", error_o, 1'b0);
    runCycle();
    idleStim(1'b1, 1'b1);
    chk("post_rst_return_err", error_o, 1'b1);
    runCycle();
    reset_i = 1'b1;
    idleStim(1'b1, 1'b1);
    runCycle();
    reset_i = 1'b0;

    // Randomized traffic with occasional resets and rare spurious returns.
    for (int c = 0; c < 3000; c++) begin
      reset_i = ($urandom_range(0, 399) == 0);
      applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, aw'($urandom),
                    rand_data(), mw'({$urandom, $urandom}),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    ($urandom_range(0, 4) == 0) && (m_reads > 0 || $urandom_range(0, 99) == 0),
                    rand_data(), aw'($urandom));
      runCycle();
    end
    reset_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsg_hbm_channel_req_adapter.md
Name: bsg_hbm_channel_req_adapter

Overview:
- Per-channel front end that sits directly upstream of one channel of bsg_nonsynth_ramulator_hbm.
- Takes a single client ready/valid request stream (command + write data + mask) and splits it onto the HBM model's independent command and write-data handshakes.
- Enforces a read-credit limit and returns read data with its address to the client.
- Instantiated once per channel, between a trace replay or cache engine and the HBM model.

Parameters:
- channel_addr_width_p, 29, channel address width.
- data_width_p, 512, data beat width; mask width = data_width_p>>3.
- cmd_els_p, 4, command FIFO depth (>=2).
- wdata_els_p, 4, write-data FIFO depth (>=2).
- max_reads_p, 16, maximum in-flight reads (>=1).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- v_i  in  1  client request valid.
- write_not_read_i  in  1  1=write, 0=read.
- addr_i  in  channel_addr_width_p  channel address.
- data_i  in  data_width_p  write data; ignored for reads.
- mask_i  in  data_width_p>>3  byte mask; ignored for reads.
- ready_and_o  out  1  request accepted when v_i & ready_and_o.
- hbm_v_o  out  1  command valid to HBM.
- hbm_write_not_read_o  out  1  command type.
- hbm_ch_addr_o  out  channel_addr_width_p  command address.
- hbm_yumi_i  in  1  HBM consumed the command.
- hbm_data_v_o  out  1  write data valid to HBM.
- hbm_data_o  out  data_width_p  write data.
- hbm_mask_o  out  data_width_p>>3  write mask.
- hbm_data_yumi_i  in  1  HBM consumed the write beat.
- hbm_data_v_i  in  1  read return valid; no backpressure.
- hbm_data_i  in  data_width_p  read return data.
- hbm_read_done_ch_addr_i  in  channel_addr_width_p  address of the returned read.
- resp_v_o  out  1  registered read response valid; no backpressure.
- resp_data_o  out  data_width_p  response data.
- resp_addr_o  out  channel_addr_width_p  response address.
- reads_outstanding_o  out  $clog2(max_reads_p+1)  in-flight read count.
- idle_o  out  1  both FIFOs empty and reads_outstanding_o==0.
- error_o  out  1  sticky: read return seen with zero outstanding.

Behaviour:
- Reset: all FIFOs empty; counter=0. hbm_v_o, hbm_data_v_o, resp_v_o and error_o are 0; idle_o=1. ready_and_o is 0 during reset.
- Accept condition (ready_and_o): cmd FIFO not full AND, for a write, wdata FIFO not full AND, for a read, reads_outstanding_o < max_reads_p.
  - ready_and_o depends on write_not_read_i (combinational).
  - Clients hold write_not_read_i stable while v_i is high.
- On accept: push {write_not_read, addr} into the cmd FIFO. For a write, also push {data, mask} into the wdata FIFO in the same cycle. For a read, increment the counter.
- Latency: an accepted request appears on hbm_v_o the next cycle, at the earliest. A write beat appears on hbm_data_v_o the next cycle, at the earliest.
- hbm_v_o = cmd FIFO not empty; pop on hbm_yumi_i. hbm_data_v_o = wdata FIFO not empty; pop on hbm_data_yumi_i. The two channels are fully independent; write beats leave in write-command order.
- Yumi asserted while the corresponding valid is low is ignored; the FIFO does not underflow.
- Read return: on hbm_data_v_i, register data and address into resp_*. resp_v_o pulses 1 cycle later and is held for exactly 1 cycle per return. The counter decrements in the same cycle hbm_data_v_i is sampled.
- Read accept and read return in the same cycle: counter unchanged. At counter==max_reads_p, a same-cycle return does NOT free a credit for that cycle's accept; the credit is usable from the next cycle.
- Return with counter==0: counter stays 0, error_o sets and stays set until reset; the response is still forwarded.
- Full FIFO pushing and popping in the same cycle: the push is still refused, because ready is computed from the registered full flags.
- Reset mid-operation: all queued commands, write beats and credits are discarded. Returns arriving in the first cycle after reset set error_o.

Decomposition:
- Package bsg_hbm_adapter_pkg holds:
  - packed struct for the command entry {write_not_read, ch_addr}, parameterised via the module's localparam struct width;
  - packed struct for the write beat {data, mask}.
- Both FIFOs are instances of the existing bsg_fifo_1r1w_small. The credit counter is bsg_counter_up_down.
- No new sub-module.

Test Plan:
- Single write addr 0x100, data 0xA5..A5, mask all ones, with hbm_yumi_i/hbm_data_yumi_i tied 1 -> hbm_v_o cycle+1 with addr 0x100, wnr=1; hbm_data_v_o cycle+1 with same data; idle_o returns to 1.
- Hold hbm_yumi_i=0, stream 5 reads, cmd_els_p=4 -> 4 accepted, ready_and_o=0 on the 5th; release yumi -> 5th accepted, order preserved.
- 16 reads issued with no returns -> 17th read refused while a write is still accepted; one return -> read accepted the next cycle; reads_outstanding_o goes 16→15→16.
- Read return addr 0x2A0 with data D -> resp_v_o one cycle later with addr 0x2A0, data D; counter decrements.
- Same-cycle read accept and return at counter=5 -> counter stays 5.
- Return with zero outstanding -> error_o=1 and stays set until reset; assert reset mid-stream with 3 queued commands -> hbm_v_o=0 and counter=0 in the cycle after reset.
